regfile_mp: RTL and testbench

- Parametrised successor to the single-cycle datapath register file.
- Generalised in data width, register count and read-port count.
- Adds a second write port, optional write-to-read bypass, async clear of all registers, and a per-register busy scoreboard for the pipelined datapath.
- Sits between decode (read addresses, issue) and writeback (two result buses: ALU and memory).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_rdport.sv | 54 +++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  localparam int REGFILE_WIDTH = 64;
  localparam int REGFILE_DEPTH = 32;
  localparam int XZR_IDX       = 31;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [63:0] reg_data_t;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: hardwired-zero register, write bypass, storage.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_IDX = XZR_IDX,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [AW-1:0]             ra,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]          busy,
  input  logic                      wrEn0,
  input  logic [AW-1:0]             wrAddr0,
  input  logic [WIDTH-1:0]          wrData0,
  input  logic                      wrEn1,
  input  logic [AW-1:0]             wrAddr1,
  input  logic [WIDTH-1:0]          wrData1,
  output logic [WIDTH-1:0]          rdData,
  output logic                      rdBusy
);

  // ZERO_IDX == DEPTH means there is no hardwired-zero register.
  localparam bit            HAS_ZERO  = (ZERO_IDX < DEPTH);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

  logic isZero_s;
  logic hit0_s;
  logic hit1_s;

  // Select the source for this port; an in-flight write counts as already retired.
  always_comb begin
    rdData   = {WIDTH{1'b0}};
    rdBusy   = 1'b0;
    isZero_s = HAS_ZERO && (ra == ZERO_ADDR);
    hit1_s   = BYPASS && wrEn1 && (wrAddr1 == ra);
    hit0_s   = BYPASS && wrEn0 && (wrAddr0 == ra);
    if (isZero_s) begin
      rdData = {WIDTH{1'b0}};
      rdBusy = 1'b0;
    end else if (hit1_s) begin
      rdData = wrData1;
      rdBusy = 1'b0;
    end else if (hit0_s) begin
      rdData = wrData0;
      rdBusy = 1'b0;
    end else begin
      rdData = regs[ra];
      rdBusy = busy[ra];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, bypass and a busy scoreboard.
// All state changes on the falling edge of Clk.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int ZERO_IDX = DEPTH - 1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                 Clk,
  input  logic                 ResetL,
  input  logic [NRD*AW-1:0]    RA,
  output logic [NRD*WIDTH-1:0] BusR,
  output logic [NRD-1:0]       RdBusy,
  input  logic [AW-1:0]        RW0,
  input  logic [WIDTH-1:0]     BusW0,
  input  logic                 RegWr0,
  input  logic [AW-1:0]        RW1,
  input  logic [WIDTH-1:0]     BusW1,
  input  logic                 RegWr1,
  input  logic                 IssueEn,
  input  logic [AW-1:0]        IssueRd,
  output logic                 WrConflict
);

  localparam bit            HAS_ZERO  = (ZERO_IDX < DEPTH);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

  logic [DEPTH-1:0][WIDTH-1:0] regs_r;
  logic [DEPTH-1:0]            busy_r;
  logic [DEPTH-1:0]            nextBusy_s;
  logic                        wrConflict_r;
  logic                        wrEn0_s;
  logic                        wrEn1_s;
  logic                        issue_s;
  logic                        conflict_s;
  logic                        bypEn0_s;
  logic                        bypEn1_s;

  // Qualify requests: anything aimed at the zero register is dropped here.
  always_comb begin
    wrEn0_s    = RegWr0 && !(HAS_ZERO && (RW0 == ZERO_ADDR));
    wrEn1_s    = RegWr1 && !(HAS_ZERO && (RW1 == ZERO_ADDR));
    issue_s    = IssueEn && !(HAS_ZERO && (IssueRd == ZERO_ADDR));
    conflict_s = wrEn0_s && wrEn1_s && (RW0 == RW1);
    // Reads must show cleared state while reset is held, so no bypass then.
    bypEn0_s   = wrEn0_s && ResetL;
    bypEn1_s   = wrEn1_s && ResetL;
  end

  // Next scoreboard: writebacks retire a producer, a new issue re-marks it (set wins).
  always_comb begin
    nextBusy_s = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      nextBusy_s[i] = (busy_r[i] &&
                       !((wrEn0_s && (RW0 == AW'(i))) || (wrEn1_s && (RW1 == AW'(i)))))
                      || (issue_s && (IssueRd == AW'(i)));
    end
  end

  // Register storage; port 1 is applied last so it wins a same-address collision.
  always_ff @(negedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      regs_r <= {(DEPTH*WIDTH){1'b0}};
    end else begin
      if (wrEn0_s) begin
        regs_r[RW0] <= BusW0;
      end
      if (wrEn1_s) begin
        regs_r[RW1] <= BusW1;
      end
    end
  end

  // Scoreboard and the one-cycle write-collision flag.
  always_ff @(negedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      busy_r       <= {DEPTH{1'b0}};
      wrConflict_r <= 1'b0;
    end else begin
      busy_r       <= nextBusy_s;
      wrConflict_r <= conflict_s;
    end
  end

  assign WrConflict = wrConflict_r;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdport #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .ZERO_IDX(ZERO_IDX),
      .BYPASS  (BYPASS)
    ) u_rdport (
      .ra     (RA[k*AW +: AW]),
      .regs   (regs_r),
      .busy   (busy_r),
      .wrEn0  (bypEn0_s),
      .wrAddr0(RW0),
      .wrData0(BusW0),
      .wrEn1  (bypEn1_s),
      .wrAddr1(RW1),
      .wrData1(BusW1),
      .rdData (BusR[k*WIDTH +: WIDTH]),
      .rdBusy (RdBusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance plus a 32-bit/16-entry/3-port variant
// with no zero register and no bypass.
module tb_regfile_mp;

  localparam int W  = 64;
  localparam int A  = 5;
  localparam int N  = 2;
  localparam int W2 = 32;
  localparam int A2 = 4;
  localparam int N2 = 3;

  logic           Clk     = 1'b0;
  logic           ResetL  = 1'b1;
  logic [N*A-1:0] RA      = 10'd0;
  logic [N*W-1:0] BusR;
  logic [N-1:0]   RdBusy;
  logic [A-1:0]   RW0     = 5'd0;
  logic [W-1:0]   BusW0   = 64'd0;
  logic           RegWr0  = 1'b0;
  logic [A-1:0]   RW1     = 5'd0;
  logic [W-1:0]   BusW1   = 64'd0;
  logic           RegWr1  = 1'b0;
  logic           IssueEn = 1'b0;
  logic [A-1:0]   IssueRd = 5'd0;
  logic           WrConflict;

  logic [N2*A2-1:0] ra2      = 12'd0;
  logic [N2*W2-1:0] busR2;
  logic [N2-1:0]    rdBusy2;
  logic [A2-1:0]    rw02     = 4'd0;
  logic [W2-1:0]    busW02   = 32'd0;
  logic             regWr02  = 1'b0;
  logic [A2-1:0]    rw12     = 4'd0;
  logic [W2-1:0]    busW12   = 32'd0;
  logic             regWr12  = 1'b0;
  logic             issueEn2 = 1'b0;
  logic [A2-1:0]    issueRd2 = 4'd0;
  logic             wrConflict2;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  regfile_mp dut (
    .Clk(Clk), .ResetL(ResetL), .RA(RA), .BusR(BusR), .RdBusy(RdBusy),
    .RW0(RW0), .BusW0(BusW0), .RegWr0(RegWr0),
    .RW1(RW1), .BusW1(BusW1), .RegWr1(RegWr1),
    .IssueEn(IssueEn), .IssueRd(IssueRd), .WrConflict(WrConflict)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(16), .NRD(3), .ZERO_IDX(16), .BYPASS(1'b0)) dut2 (
    .Clk(Clk), .ResetL(ResetL), .RA(ra2), .BusR(busR2), .RdBusy(rdBusy2),
    .RW0(rw02), .BusW0(busW02), .RegWr0(regWr02),
    .RW1(rw12), .BusW1(busW12), .RegWr1(regWr12),
    .IssueEn(issueEn2), .IssueRd(issueRd2), .WrConflict(wrConflict2)
  );

  // Reference architectural state.
  logic [63:0] mRegs  [32];
  logic        mBusy  [32];
  logic        mConf;
  logic [31:0] m2Regs [16];
  logic        m2Busy [16];
  logic        m2Conf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: effect of each falling edge, cleared at once by reset.
  always @(negedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      for (int i = 0; i < 32; i++) begin
        mRegs[i] <= 64'd0;
        mBusy[i] <= 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
        m2Regs[i] <= 32'd0;
        m2Busy[i] <= 1'b0;
      end
      mConf  <= 1'b0;
      m2Conf <= 1'b0;
    end else begin
      if (RegWr0 && RW0 != 5'd31) begin mRegs[RW0] <= BusW0; mBusy[RW0] <= 1'b0; end
      if (RegWr1 && RW1 != 5'd31) begin mRegs[RW1] <= BusW1; mBusy[RW1] <= 1'b0; end
      if (IssueEn && IssueRd != 5'd31) mBusy[IssueRd] <= 1'b1;
      mConf <= RegWr0 && RegWr1 && (RW0 == RW1) && (RW0 != 5'd31);
      if (regWr02) begin m2Regs[rw02] <= busW02; m2Busy[rw02] <= 1'b0; end
      if (regWr12) begin m2Regs[rw12] <= busW12; m2Busy[rw12] <= 1'b0; end
      if (issueEn2) m2Busy[issueRd2] <= 1'b1;
      m2Conf <= regWr02 && regWr12 && (rw02 == rw12);
    end
  end

  function automatic logic [63:0] expRd(input logic [4:0] a);
    if (!ResetL || a == 5'd31) return 64'd0;
    if (RegWr1 && RW1 == a) return BusW1;
    if (RegWr0 && RW0 == a) return BusW0;
    return mRegs[a];
  endfunction

  function automatic logic expBusy(input logic [4:0] a);
    if (!ResetL || a == 5'd31) return 1'b0;
    if ((RegWr1 && RW1 == a) || (RegWr0 && RW0 == a)) return 1'b0;
    return mBusy[a];
  endfunction

  // Every rising edge (mid-cycle, inputs stable) compare all outputs to the model.
  always @(posedge Clk) begin
    for (int k = 0; k < N; k++) begin
      check("cyc_busR", BusR[k*W +: W], expRd(RA[k*A +: A]));
      check("cyc_rdBusy", 64'(RdBusy[k]), 64'(expBusy(RA[k*A +: A])));
    end
    check("cyc_wrConflict", 64'(WrConflict), 64'(mConf));
    for (int k = 0; k < N2; k++) begin
      check("cyc2_busR", 64'(busR2[k*W2 +: W2]),
            64'(ResetL ? m2Regs[ra2[k*A2 +: A2]] : 32'd0));
      check("cyc2_rdBusy", 64'(rdBusy2[k]),
            64'(ResetL ? m2Busy[ra2[k*A2 +: A2]] : 1'b0));
    end
    check("cyc2_wrConflict", 64'(wrConflict2), 64'(m2Conf));
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic idle();
    RegWr0   = 1'b0;
    RegWr1   = 1'b0;
    IssueEn  = 1'b0;
    regWr02  = 1'b0;
    regWr12  = 1'b0;
    issueEn2 = 1'b0;
  endtask

  initial begin
    #1 ResetL = 1'b0;
    tick();
    tick();
    check("rst_busR0", BusR[63:0], 64'd0);
    check("rst_rdBusy", 64'(RdBusy), 64'd0);
    check("rst_wrConflict", 64'(WrConflict), 64'd0);
    ResetL = 1'b1;
    #1;
    check("rel_busR1", BusR[127:64], 64'd0);

    // 1: writes to the zero register are discarded
    RA = {5'd31, 5'd31};
    RW0 = 5'd31; BusW0 = 64'h12345678; RegWr0 = 1'b1;
    #1;
    check("zero_pre_busR0", BusR[63:0], 64'd0);
    check("zero_pre_busR1", BusR[127:64], 64'd0);
    check("zero_pre_rdBusy", 64'(RdBusy), 64'd0);
    tick();
    check("zero_post_busR0", BusR[63:0], 64'd0);
    check("zero_post_rdBusy", 64'(RdBusy), 64'd0);
    idle();

    // 2: fill r1..r30 through alternating ports, read back in pairs
    for (int i = 1; i <= 30; i++) begin
      if (i % 2 == 1) begin
        RW0 = 5'(i); BusW0 = 64'(i); RegWr0 = 1'b1; RegWr1 = 1'b0;
      end else begin
        RW1 = 5'(i); BusW1 = 64'(i); RegWr1 = 1'b1; RegWr0 = 1'b0;
      end
      tick();
    end
    idle();
    for (int i = 1; i < 30; i += 2) begin
      RA = {5'(i + 1), 5'(i)};
      #1;
      check("fill_lo", BusR[63:0], 64'(i));
      check("fill_hi", BusR[127:64], 64'(i + 1));
    end
    BusW0 = 64'hDEADBEEF; BusW1 = 64'hDEADBEEF; RW0 = 5'd1; RW1 = 5'd2;
    tick();
    for (int i = 1; i < 30; i += 2) begin
      RA = {5'(i + 1), 5'(i)};
      #1;
      check("nowr_lo", BusR[63:0], 64'(i));
      check("nowr_hi", BusR[127:64], 64'(i + 1));
    end
    tick();

    // 3: same-address double write, port 1 wins and the collision flag pulses
    RA = {5'd0, 5'd5};
    RW0 = 5'd5; RW1 = 5'd5; BusW0 = 64'hAAAA; BusW1 = 64'hBBBB;
    RegWr0 = 1'b1; RegWr1 = 1'b1;
    #1;
    check("coll_pre_busR0", BusR[63:0], 64'hBBBB);
    check("coll_pre_flag", 64'(WrConflict), 64'd0);
    tick();
    check("coll_post_busR0", BusR[63:0], 64'hBBBB);
    check("coll_flag_set", 64'(WrConflict), 64'd1);
    idle();
    tick();
    check("coll_flag_clr", 64'(WrConflict), 64'd0);
    check("coll_stored", BusR[63:0], 64'hBBBB);

    // 4: scoreboard set, bypass clear, set-beats-clear
    RA = {5'd0, 5'd7};
    IssueEn = 1'b1; IssueRd = 5'd7;
    tick();
    IssueEn = 1'b0;
    #1;
    check("sb_busy_set", 64'(RdBusy[0]), 64'd1);
    RegWr0 = 1'b1; RW0 = 5'd7; BusW0 = 64'h77;
    #1;
    check("sb_byp_busy", 64'(RdBusy[0]), 64'd0);
    check("sb_byp_data", BusR[63:0], 64'h77);
    tick();
    idle();
    #1;
    check("sb_cleared", 64'(RdBusy[0]), 64'd0);
    check("sb_data", BusR[63:0], 64'h77);
    IssueEn = 1'b1; IssueRd = 5'd7; RegWr0 = 1'b1; RW0 = 5'd7; BusW0 = 64'h78;
    #1;
    check("sb_both_pre", 64'(RdBusy[0]), 64'd0);
    tick();
    idle();
    #1;
    check("sb_set_wins", 64'(RdBusy[0]), 64'd1);
    check("sb_set_data", BusR[63:0], 64'h78);

    // 5: asynchronous reset in the middle of a cycle
    RA = {5'd7, 5'd3};
    RW0 = 5'd3; BusW0 = 64'h33; RegWr0 = 1'b1;
    tick();
    RW0 = 5'd9; RW1 = 5'd9; BusW0 = 64'd1; BusW1 = 64'd2; RegWr1 = 1'b1;
    #1;
    check("mid_r3", BusR[63:0], 64'h33);
    check("mid_r7_busy", 64'(RdBusy[1]), 64'd1);
    tick();
    idle();
    #1;
    check("mid_flag", 64'(WrConflict), 64'd1);
    @(posedge Clk);
    #2;
    ResetL = 1'b0;
    RegWr0 = 1'b1; RW0 = 5'd3; BusW0 = 64'h99; IssueEn = 1'b1; IssueRd = 5'd3;
    #1;
    check("arst_r3", BusR[63:0], 64'd0);
    check("arst_r7", BusR[127:64], 64'd0);
    check("arst_busy", 64'(RdBusy), 64'd0);
    check("arst_flag", 64'(WrConflict), 64'd0);
    tick();
    idle();
    ResetL = 1'b1;
    #1;
    check("arst_rel_r3", BusR[63:0], 64'd0);
    check("arst_rel_busy", 64'(RdBusy), 64'd0);

    // 6: 32-bit / 16-entry / 3-port variant, no zero register, no bypass
    ra2 = {4'd15, 4'd0, 4'd15};
    rw02 = 4'd15; busW02 = 32'hF; regWr02 = 1'b1;
    #1;
    check("p2_nobyp_old", 64'(busR2[31:0]), 64'd0);
    tick();
    regWr02 = 1'b0;
    #1;
    check("p2_r15", 64'(busR2[31:0]), 64'hF);
    check("p2_r15_port2", 64'(busR2[95:64]), 64'hF);
    rw12 = 4'd15; busW12 = 32'h5A; regWr12 = 1'b1;
    #1;
    check("p2_hold_old", 64'(busR2[31:0]), 64'hF);
    tick();
    idle();
    #1;
    check("p2_new", 64'(busR2[31:0]), 64'h5A);
    rw02 = 4'd0; busW02 = 32'h0A0A; regWr02 = 1'b1;
    tick();
    idle();
    #1;
    check("p2_r0", 64'(busR2[63:32]), 64'h0A0A);
    ra2 = {4'd15, 4'd4, 4'd15};
    issueEn2 = 1'b1; issueRd2 = 4'd4;
    tick();
    issueEn2 = 1'b0; regWr02 = 1'b1; rw02 = 4'd4; busW02 = 32'h44;
    #1;
    check("p2_busy_nobyp", 64'(rdBusy2[1]), 64'd1);
    check("p2_data_nobyp", 64'(busR2[63:32]), 64'd0);
    tick();
    idle();
    #1;
    check("p2_busy_clr", 64'(rdBusy2[1]), 64'd0);
    check("p2_r4", 64'(busR2[63:32]), 64'h44);
    rw02 = 4'd2; rw12 = 4'd2; busW02 = 32'd1; busW12 = 32'd2;
    regWr02 = 1'b1; regWr12 = 1'b1;
    tick();
    idle();
    #1;
    check("p2_flag_set", 64'(wrConflict2), 64'd1);
    tick();
    check("p2_flag_clr", 64'(wrConflict2), 64'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
